// File: rtl/tp_montre_cpu_ocimem_ctrl.sv
// On-chip debug memory controller: executes JTAG debug-module commands on a
// 2^ADDR_W x 32 debug RAM and shares that RAM with a CPU-side Avalon-MM slave.
module tp_montre_cpu_ocimem_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic              avs_waitrequest
);

    // Avalon handshake: a request (avs_read or avs_write) is held by the master
    // until a cycle in which avs_waitrequest=0; that cycle completes it.
    typedef enum logic [1:0] {IDLE, RD, RD_CAP, WR} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] mon_areg;
    logic [31:0]       wdata_q;
    logic [31:0]       ram_q;
    logic              rd_pend;
    logic [31:0]       mem [0:(1<<ADDR_W)-1];

    logic              any_strobe, idle, accept;
    logic              cmd_a, cmd_b, cmd_n;
    logic              cpu_req, cpu_grant;
    logic              ram_we, ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic              unused_jdo;

    assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

    always_comb begin
        any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
        idle       = (state == IDLE);
        accept     = idle & any_strobe;
        cmd_a      = take_action_ocimem_a;
        cmd_b      = take_action_ocimem_b & ~take_action_ocimem_a;
        cmd_n      = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;

        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_a && jdo[34]) state_nxt = RD;
                else if (cmd_b)       state_nxt = WR;
                else if (cmd_n)       state_nxt = RD;
            end
            RD:      state_nxt = RD_CAP;
            RD_CAP:  state_nxt = IDLE;
            WR:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // JTAG owns the RAM in RD/WR; the cycle after a granted CPU read is its
        // completion cycle, so no new grant is issued then.
        cpu_req   = avs_read | avs_write;
        cpu_grant = cpu_req & ~rd_pend & ~accept & (idle | (state == RD_CAP));

        ram_we    = (state == WR) | (cpu_grant & avs_write);
        ram_re    = (state == RD) | (cpu_grant & ~avs_write);
        ram_addr  = ((state == RD) || (state == WR)) ? mon_areg : avs_address;
        ram_wdata = (state == WR) ? wdata_q : avs_writedata;

        avs_waitrequest = cpu_req & ~(cpu_grant & avs_write) & ~rd_pend;
    end

    // Gating on reset_n suppresses a WR-cycle write that coincides with reset.
    always_ff @(posedge clk) begin
        if (ram_we && reset_n) mem[ram_addr] <= ram_wdata;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            mon_areg      <= '0;
            wdata_q       <= '0;
            ram_q         <= '0;
            rd_pend       <= 1'b0;
            MonDReg       <= '0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
        end else begin
            state   <= state_nxt;
            rd_pend <= cpu_grant & ~avs_write;
            if (ram_re) ram_q <= mem[ram_addr];

            if (accept && cmd_a)
                mon_areg <= jdo[17 +: ADDR_W];
            else if ((state == RD_CAP) || (state == WR))
                mon_areg <= mon_areg + 1'b1;

            if (accept && cmd_b) wdata_q <= jdo[34:3];
            if (state == RD_CAP) MonDReg <= ram_q;

            if (accept)
                monitor_ready <= cmd_a & ~jdo[34];
            else if ((state == RD_CAP) || (state == WR))
                monitor_ready <= 1'b1;

            // A strobe while busy is an overrun; it beats any clear request.
            if (!idle && any_strobe)
                monitor_error <= 1'b1;
            else if (accept && cmd_a && jdo[35])
                monitor_error <= 1'b0;
        end
    end

    assign avs_readdata = ram_q;

endmodule

// File: doc/tp_montre_cpu_ocimem_ctrl.md
# tp_montre_cpu_ocimem_ctrl

On-chip debug memory controller for the Nios II debug path. It sits directly downstream of the JTAG debug module wrapper. It consumes that wrapper's system-clock command strobes (`take_action_ocimem_a`, `take_action_ocimem_b`, `take_no_action_ocimem_a`) and the 38-bit `jdo` payload, and executes reads and writes on a 2^ADDR_W × 32 debug RAM. It returns `MonDReg`, `monitor_ready` and `monitor_error` to the wrapper, and arbitrates the same RAM with a CPU-side Avalon-MM slave port used by the monitor code.

## Interface
Parameters:
- ADDR_W, 8, word-address width of the debug RAM (RAM depth = 2^ADDR_W words).

Ports:
- clk  in  1  system clock; the only clock.
- reset_n  in  1  reset, synchronous, active-low.
- jdo  in  38  command payload from the JTAG debug module.
- take_action_ocimem_a  in  1  one-cycle strobe: address/control command.
- take_action_ocimem_b  in  1  one-cycle strobe: write-data command.
- take_no_action_ocimem_a  in  1  one-cycle strobe: read-next command.
- MonDReg  out  32  monitor data register; read data returned to JTAG.
- monitor_ready  out  1  last JTAG-initiated operation is complete.
- monitor_error  out  1  sticky overrun flag.
- avs_address  in  ADDR_W  CPU word address.
- avs_read  in  1  CPU read request.
- avs_write  in  1  CPU write request.
- avs_writedata  in  32  CPU write data.
- avs_readdata  out  32  CPU read data.
- avs_waitrequest  out  1  CPU stall.

## Operation
- Internal registers:
  - MonAReg, ADDR_W bits: JTAG address pointer.
  - wdata_q, 32 bits.
  - state, one of IDLE, RD, RD_CAP, WR.
- RAM: single-port, synchronous read with 1-cycle latency. RAM contents are not affected by reset.
- Command decode. Commands are accepted only in IDLE.
  - take_action_ocimem_a:
    - MonAReg <= jdo[17+ADDR_W-1:17].
    - If jdo[35]=1, clear monitor_error.
    - If jdo[34]=1, go to RD; otherwise stay in IDLE and set monitor_ready=1.
  - take_action_ocimem_b: wdata_q <= jdo[34:3]; go to WR.
  - take_no_action_ocimem_a: go to RD using the current MonAReg.
  - Strobes are mutually exclusive by construction. If more than one is asserted, priority is a > b > no_action_a.
- Accepting any command clears monitor_ready.
- FSM transitions:
  - IDLE → RD or WR on a command, as above.
  - RD: RAM address = MonAReg → RD_CAP.
  - RD_CAP: MonDReg <= RAM q; MonAReg <= MonAReg+1; monitor_ready <= 1 → IDLE.
  - WR: RAM[MonAReg] <= wdata_q; MonAReg <= MonAReg+1; monitor_ready <= 1 → IDLE.
- Overrun: any strobe arriving while state ≠ IDLE is discarded and sets monitor_error=1. This includes an `a` strobe carrying jdo[35]=1; the error set wins.
- MonAReg wraps from 2^ADDR_W−1 to 0.
- CPU port arbitration:
  - The JTAG FSM owns the RAM in RD and WR.
  - The CPU is granted only in IDLE and RD_CAP, and only when no strobe is accepted that cycle (JTAG has priority).
  - CPU write: completes in its granted cycle, with avs_waitrequest=0 that cycle.
  - CPU read: the granted cycle issues the address with avs_waitrequest=1. The next cycle presents avs_readdata with avs_waitrequest=0.
  - If a JTAG op grabs the RAM in that second cycle, the read-data register still holds the CPU data; completion is not delayed.
  - avs_waitrequest=1 whenever avs_read or avs_write is asserted but not yet complete; otherwise 0.
  - avs_read and avs_write both high is treated as a write.
- Reset (reset_n=0 sampled at a clk edge):
  - State → IDLE; MonAReg=0; MonDReg=0; monitor_ready=0; monitor_error=0; avs_readdata=0; any pending CPU read is aborted.
  - A RAM write whose WR cycle coincides with reset_n=0 is suppressed.

## Timing
- JTAG read: strobe in cycle T → RD in T+1 → RD_CAP in T+2 → MonDReg and monitor_ready valid in T+3.
- JTAG write: strobe in T → WR in T+1 (RAM written at the end of T+1) → monitor_ready valid in T+2.
- Address-only command (jdo[34]=0): monitor_ready and MonAReg updated in T+1.
- Minimum spacing between accepted commands: 3 cycles for reads, 2 for writes.
- Uncontended CPU access: write takes 1 cycle, read takes 2. Each cycle the RAM is held by JTAG adds one stall cycle.
- All outputs are registered, except avs_waitrequest (combinational from request, state and grant).

## Test plan
- Reset, then a: jdo[24:17]=0x10, jdo[34]=0 → MonAReg=0x10; monitor_ready=1 at T+1; monitor_error=0.
- b with jdo[34:3]=0xDEADBEEF, then after 2 cycles no_action_a following a: addr 0x10, jdo[34]=1 → RAM[0x10]=0xDEADBEEF; MonDReg=0xDEADBEEF at T+3; MonAReg=0x11.
- a: addr 0xFF, jdo[34]=1, then no_action_a → MonAReg wraps to 0x00, then 0x01; the second read returns RAM[0x00].
- b strobe one cycle after a read strobe → b discarded; monitor_error=1. A subsequent a with jdo[35]=1 → monitor_error=0.
- CPU read of 0x20 (preloaded 0x12345678) asserted in the same cycle as an a read strobe → JTAG completes at T+3. CPU stalls until the RAM is free, then gets 0x12345678 with avs_waitrequest=0 exactly one cycle after grant.
- reset_n=0 during the WR cycle of a write of 0xCAFEF00D to 0x05 → RAM[0x05] unchanged; all outputs at reset values; state IDLE next cycle.
